multicycle_ctrl: RTL

Multi-cycle sequencer for the 64-bit RISC-V datapath. It replaces single-cycle control with a FETCH/DECODE/EXEC/MEM/WB state machine, so one shared memory port serves both instruction fetch and data access through a req/ready handshake. It drives the PC, IR, register-file, ALU and memory enables each cycle, counts retired instructions, and halts on ecall, an illegal opcode, or a memory timeout.

---
 rtl/multicycle_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 64-bit RISC-V datapath.
// One shared memory port with req/ready handshake, retire counter and sticky halt causes.
module multicycle_ctrl #(
  parameter int unsigned RET_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             jal,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [RET_W-1:0] retired
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_SD, C_BEQ, C_JAL, C_ECALL, C_ILL
  } cls_t;

  state_t           st;
  cls_t             cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             ill_q;
  logic             to_q;
  logic [RET_W-1:0] ret_q;
  logic             retire;
  logic             wait_hit;

  function automatic cls_t decode_cls(input logic [6:0] op);
    case (op)
      7'b0110011: decode_cls = C_R;
      7'b0010011: decode_cls = C_I;
      7'b0000011: decode_cls = C_LD;
      7'b0100011: decode_cls = C_SD;
      7'b1100011: decode_cls = C_BEQ;
      7'b1101111: decode_cls = C_JAL;
      7'b1110011: decode_cls = C_ECALL;
      default:    decode_cls = C_ILL;
    endcase
  endfunction

  // Strobes are gated by reset so they drop the moment reset asserts,
  // even though FETCH with run_en=1 would otherwise request memory.
  always_comb begin
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    jal        = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    retire     = 1'b0;
    if (reset) begin
      case (st)
        S_FETCH: begin
          // A nonzero wait count means a fetch is already outstanding.
          if (run_en || (wait_cnt != '0)) begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            ir_write = mem_ready;
          end
        end
        S_EXEC: begin
          case (cls)
            C_R: alu_op = 2'b10;
            C_I: begin
              alu_src = 1'b1;
              alu_op  = 2'b10;
            end
            C_LD, C_SD: alu_src = 1'b1;
            C_BEQ: begin
              alu_op   = 2'b01;
              pc_write = 1'b1;
              pc_src   = {1'b0, zero};
              retire   = 1'b1;
            end
            C_JAL: begin
              reg_write = 1'b1;
              jal       = 1'b1;
              pc_write  = 1'b1;
              pc_src    = 2'b10;
              retire    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_sel   = 1'b1;
          alu_src   = 1'b1;
          mem_read  = (cls == C_LD);
          mem_write = (cls == C_SD);
          mdr_write = (cls == C_LD) && mem_ready;
          if ((cls == C_SD) && mem_ready) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == C_LD);
          if (cls == C_R) alu_op = 2'b10;
          if (cls == C_I) begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
          end
          pc_write = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wait_hit = mem_req && !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= S_FETCH;
      cls      <= C_R;
      wait_cnt <= '0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
      ret_q    <= '0;
    end else begin
      if (retire) ret_q <= ret_q + 1'b1;
      if (mem_req) begin
        if (mem_ready || wait_hit) wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 1'b1;
      end
      case (st)
        S_FETCH: begin
          if (wait_hit) begin
            st   <= S_HALT;
            to_q <= 1'b1;
          end else if (ir_write) begin
            st <= S_DECODE;
          end
        end
        S_DECODE: begin
          cls <= decode_cls(opcode);
          case (decode_cls(opcode))
            C_ILL: begin
              st    <= S_HALT;
              ill_q <= 1'b1;
            end
            C_ECALL: st <= S_HALT;
            default: st <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_R, C_I:   st <= S_WB;
            C_LD, C_SD: st <= S_MEM;
            default:    st <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (wait_hit) begin
            st   <= S_HALT;
            to_q <= 1'b1;
          end else if (mem_ready) begin
            st <= (cls == C_LD) ? S_WB : S_FETCH;
          end
        end
        S_WB:    st <= S_FETCH;
        S_HALT:  st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

  assign state   = st;
  assign halted  = (st == S_HALT);
  assign illegal = ill_q;
  assign timeout = to_q;
  assign retired = ret_q;

endmodule
